// File: rtl/cmd_receiver_if.sv
// Command bus between a strobe-driven command source and cmd_receiver.
// Latency: none (wires only).
// Backpressure: none; strobes are level-qualified and readback never stalls.
interface cmd_receiver_if;
    logic [7:0]  addr_in;
    logic [7:0]  data_in;
    logic        sw_in;
    logic [31:0] data32_in;
    logic        sw32_in;
    logic [7:0]  rd_addr;
    logic        rd_req;
    logic        wr_pulse;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr32_pulse;
    logic [31:0] wr32_data;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        err_short;
    logic        err_range;
    logic        busy;

    modport master (
        output addr_in, data_in, sw_in, data32_in, sw32_in, rd_addr, rd_req,
        input  wr_pulse, wr_addr, wr_data, wr32_pulse, wr32_data,
               rd_data, rd_valid, err_short, err_range, busy
    );

    modport slave (
        input  addr_in, data_in, sw_in, data32_in, sw32_in, rd_addr, rd_req,
        output wr_pulse, wr_addr, wr_data, wr32_pulse, wr32_data,
               rd_data, rd_valid, err_short, err_range, busy
    );
endinterface

// File: rtl/cmd_receiver.sv
// Qualifies stretched write strobes (QUAL high samples) and commits to an NREG x 8 register file; 32-bit path under CMD_RECEIVER_DATA32_EN.
// Latency: commit pulse QUAL cycles after the first high strobe sample; readback one cycle after rd_req.
// Backpressure: none; a held strobe commits once and the FSM waits in HOLD until strobes drop.
module cmd_receiver #(
    parameter int NREG = 16,
    parameter int QUAL = 4
) (
    input  logic           clk,
    input  logic           reset,
    cmd_receiver_if.slave  bus
);

    localparam logic [7:0] QUAL_W = 8'(QUAL);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUAL8    = 3'd1,
`ifdef CMD_RECEIVER_DATA32_EN
        QUAL32   = 3'd2,
        COMMIT32 = 3'd4,
`endif
        COMMIT8  = 3'd3,
        HOLD     = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        sw_q, sw_d;
    logic [7:0]  cap_addr_q, cap_addr_d;
    logic [7:0]  cap_data_q, cap_data_d;
    logic [7:0]  reg_q [NREG];
    logic [7:0]  reg_d [NREG];
    logic        wr_pulse_q, wr_pulse_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_short_q, err_short_d;
    logic        err_range_q, err_range_d;
    logic        hit;
    logic        sw_rise;
    logic        strobes_low;

`ifdef CMD_RECEIVER_DATA32_EN
    logic        sw32_q, sw32_d;
    logic [31:0] cap32_q, cap32_d;
    logic        wr32_pulse_q, wr32_pulse_d;
    logic [31:0] wr32_data_q, wr32_data_d;
    logic        sw32_rise;

    assign sw32_rise   = bus.sw32_in & ~sw32_q;
    assign strobes_low = ~bus.sw_in & ~bus.sw32_in;
`else
    logic unused_data32;

    assign unused_data32 = ^{bus.sw32_in, bus.data32_in};
    assign strobes_low   = ~bus.sw_in;
`endif

    assign sw_rise = bus.sw_in & ~sw_q;

    // Next-state, register-file update and output-pulse generation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sw_d        = bus.sw_in;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        reg_d       = reg_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_short_d = 1'b0;
        err_range_d = 1'b0;
        hit         = 1'b0;
`ifdef CMD_RECEIVER_DATA32_EN
        sw32_d       = bus.sw32_in;
        cap32_d      = cap32_q;
        wr32_pulse_d = 1'b0;
        wr32_data_d  = wr32_data_q;
`endif
        case (state_q)
            IDLE: begin
                // 8-bit strobe wins when both rise together.
                if (sw_rise) begin
                    count_d    = 8'd1;
                    cap_addr_d = bus.addr_in;
                    cap_data_d = bus.data_in;
                    state_d    = (QUAL_W == 8'd1) ? COMMIT8 : QUAL8;
                end
`ifdef CMD_RECEIVER_DATA32_EN
                else if (sw32_rise) begin
                    count_d = 8'd1;
                    cap32_d = bus.data32_in;
                    state_d = (QUAL_W == 8'd1) ? COMMIT32 : QUAL32;
                end
`endif
            end
            QUAL8: begin
                // Recapturing every high cycle leaves the qualifying cycle's value.
                if (bus.sw_in) begin
                    count_d    = count_q + 8'd1;
                    cap_addr_d = bus.addr_in;
                    cap_data_d = bus.data_in;
                    if (count_q + 8'd1 == QUAL_W) state_d = COMMIT8;
                end else begin
                    err_short_d = 1'b1;
                    count_d     = 8'd0;
                    state_d     = IDLE;
                end
            end
            COMMIT8: begin
                for (int i = 0; i < NREG; i++) begin
                    if (cap_addr_q == 8'(i)) begin
                        hit      = 1'b1;
                        reg_d[i] = cap_data_q;
                    end
                end
                if (hit) begin
                    wr_pulse_d = 1'b1;
                    wr_addr_d  = cap_addr_q;
                    wr_data_d  = cap_data_q;
                end else begin
                    err_range_d = 1'b1;
                end
                count_d = 8'd0;
                state_d = HOLD;
            end
`ifdef CMD_RECEIVER_DATA32_EN
            QUAL32: begin
                if (bus.sw32_in) begin
                    count_d = count_q + 8'd1;
                    cap32_d = bus.data32_in;
                    if (count_q + 8'd1 == QUAL_W) state_d = COMMIT32;
                end else begin
                    err_short_d = 1'b1;
                    count_d     = 8'd0;
                    state_d     = IDLE;
                end
            end
            COMMIT32: begin
                wr32_pulse_d = 1'b1;
                wr32_data_d  = cap32_q;
                count_d      = 8'd0;
                state_d      = HOLD;
            end
`endif
            HOLD: begin
                if (strobes_low) state_d = IDLE;
            end
            default: begin
                count_d = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Readback path: reads the pre-commit contents, independent of FSM state.
    always_comb begin
        rd_valid_d = bus.rd_req;
        rd_data_d  = rd_data_q;
        if (bus.rd_req) begin
            rd_data_d = 8'h00;
            for (int i = 0; i < NREG; i++) begin
                if (bus.rd_addr == 8'(i)) rd_data_d = reg_q[i];
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            sw_q        <= 1'b0;
            cap_addr_q  <= 8'h00;
            cap_data_q  <= 8'h00;
            reg_q       <= '{default: 8'h00};
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_range_q <= 1'b0;
`ifdef CMD_RECEIVER_DATA32_EN
            sw32_q       <= 1'b0;
            cap32_q      <= 32'h0;
            wr32_pulse_q <= 1'b0;
            wr32_data_q  <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sw_q        <= sw_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            reg_q       <= reg_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_short_q <= err_short_d;
            err_range_q <= err_range_d;
`ifdef CMD_RECEIVER_DATA32_EN
            sw32_q       <= sw32_d;
            cap32_q      <= cap32_d;
            wr32_pulse_q <= wr32_pulse_d;
            wr32_data_q  <= wr32_data_d;
`endif
        end
    end

    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.err_short = err_short_q;
    assign bus.err_range = err_range_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef CMD_RECEIVER_DATA32_EN
    assign bus.wr32_pulse = wr32_pulse_q;
    assign bus.wr32_data  = wr32_data_q;
`else
    assign bus.wr32_pulse = 1'b0;
    assign bus.wr32_data  = 32'h0;
`endif

endmodule

// File: tb/tb_cmd_receiver.sv
// Directed bench for cmd_receiver (NREG=16, QUAL=4): vector table plus hand sequences.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: none; every wait is a fixed cycle count.
module tb_cmd_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cmd_receiver_if bus ();

    cmd_receiver #(.NREG(16), .QUAL(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt, wr32_cnt, short_cnt, range_cnt, busy_cnt, cyc, wr_at, wr32_at;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         hold;
        int         exp_wr;
        int         exp_short;
        int         exp_range;
        logic [7:0] exp_wa;
        logic [7:0] exp_wd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        wr_cnt = 0; wr32_cnt = 0; short_cnt = 0; range_cnt = 0; busy_cnt = 0;
        cyc = 0; wr_at = -1; wr32_at = -1;
    endtask

    // One clock: sample outputs on the falling edge and accumulate pulse counts.
    task automatic step();
        @(negedge clk);
        if (bus.wr_pulse === 1'b1) begin wr_cnt++; if (wr_at < 0) wr_at = cyc; end
        if (bus.wr32_pulse === 1'b1) begin wr32_cnt++; if (wr32_at < 0) wr32_at = cyc; end
        if (bus.err_short === 1'b1) short_cnt++;
        if (bus.err_range === 1'b1) range_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        cyc++;
    endtask

    task automatic strobe8(input logic [7:0] a, input logic [7:0] d, input int n);
        clr_mon();
        bus.addr_in = a;
        bus.data_in = d;
        bus.sw_in   = 1'b1;
        for (int j = 0; j < n; j++) step();
        bus.sw_in = 1'b0;
        for (int j = 0; j < 5; j++) step();
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        @(negedge clk);
        check({name, "_vld"}, 32'(bus.rd_valid), 32'd1);
        check({name, "_dat"}, 32'(bus.rd_data), 32'(exp));
        bus.rd_req = 1'b0;
        @(negedge clk);
        check({name, "_vld_drop"}, 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h03, 8'hA5, 20, 1, 0, 0, 8'h03, 8'hA5, 8'hA5};
        vecs[1] = '{8'h05, 8'h77,  2, 0, 1, 0, 8'h03, 8'hA5, 8'h00};
        vecs[2] = '{8'h20, 8'h11, 20, 0, 0, 1, 8'h03, 8'hA5, 8'h00};
        vecs[3] = '{8'h0F, 8'hC3,  4, 1, 0, 0, 8'h0F, 8'hC3, 8'hC3};
        vecs[4] = '{8'h00, 8'hFF,  3, 0, 1, 0, 8'h0F, 8'hC3, 8'h00};
        vecs[5] = '{8'h10, 8'h01,  5, 0, 0, 1, 8'h0F, 8'hC3, 8'h00};
        vecs[6] = '{8'h0A, 8'h3C,  4, 1, 0, 0, 8'h0A, 8'h3C, 8'h3C};
        vecs[7] = '{8'h00, 8'h81,  6, 1, 0, 0, 8'h00, 8'h81, 8'h81};

        bus.addr_in = 8'h00; bus.data_in = 8'h00; bus.sw_in = 1'b0;
        bus.data32_in = 32'h0; bus.sw32_in = 1'b0;
        bus.rd_addr = 8'h00; bus.rd_req = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.wr_pulse, bus.wr32_pulse, bus.rd_valid, bus.err_short,
                              bus.err_range, bus.busy}, 32'd0);
        check("rst_wr_bus", {bus.wr_addr, bus.wr_data, bus.rd_data}, 32'd0);
        check("rst_wr32_data", bus.wr32_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table of 8-bit commands.
        for (int i = 0; i < 8; i++) begin
            strobe8(vecs[i].addr, vecs[i].data, vecs[i].hold);
            check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_short_cnt", i), 32'(short_cnt), 32'(vecs[i].exp_short));
            check($sformatf("v%0d_range_cnt", i), 32'(range_cnt), 32'(vecs[i].exp_range));
            check($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].exp_wa));
            check($sformatf("v%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].exp_wd));
            if (vecs[i].exp_wr != 0)
                check($sformatf("v%0d_latency", i), 32'(wr_at), 32'd4);
            check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 32'd0);
            rd_check($sformatf("v%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
        end

        // Readback on the commit edge sees the old value; long hold commits once.
        clr_mon();
        bus.addr_in = 8'h03; bus.data_in = 8'h42; bus.sw_in = 1'b1;
        repeat (4) step();
        bus.rd_addr = 8'h03; bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        check("same_edge_wr_at", 32'(wr_at), 32'd4);
        check("same_edge_rd_vld", 32'(bus.rd_valid), 32'd1);
        check("same_edge_rd_old", 32'(bus.rd_data), 32'hA5);
        repeat (15) step();
        check("hold_busy", 32'(bus.busy), 32'd1);
        check("hold_one_commit", 32'(wr_cnt), 32'd1);
        bus.sw_in = 1'b0;
        repeat (4) step();
        check("hold_release_busy", 32'(bus.busy), 32'd0);
        rd_check("same_edge_rd_new", 8'h03, 8'h42);

`ifdef CMD_RECEIVER_DATA32_EN
        // Both strobes rise together: 8-bit wins, 32-bit ignored until both drop.
        clr_mon();
        bus.addr_in = 8'h04; bus.data_in = 8'h12; bus.data32_in = 32'hDEADBEEF;
        bus.sw_in = 1'b1; bus.sw32_in = 1'b1;
        repeat (8) step();
        bus.sw_in = 1'b0;
        repeat (8) step();
        check("both_busy_cnt", 32'(busy_cnt), 32'd16);
        bus.sw32_in = 1'b0;
        repeat (4) step();
        check("both_wr_cnt", 32'(wr_cnt), 32'd1);
        check("both_wr32_cnt", 32'(wr32_cnt), 32'd0);
        check("both_wr32_data", bus.wr32_data, 32'd0);
        rd_check("both_rd", 8'h04, 8'h12);
        clr_mon();
        bus.sw32_in = 1'b1;
        repeat (6) step();
        bus.sw32_in = 1'b0;
        repeat (4) step();
        check("w32_cnt", 32'(wr32_cnt), 32'd1);
        check("w32_latency", 32'(wr32_at), 32'd4);
        check("w32_data", bus.wr32_data, 32'hDEADBEEF);
        check("w32_no_wr8", 32'(wr_cnt), 32'd0);
`else
        // Without the 32-bit path the wide strobe is ignored entirely.
        clr_mon();
        bus.data32_in = 32'hDEADBEEF; bus.sw32_in = 1'b1;
        repeat (20) step();
        bus.sw32_in = 1'b0;
        repeat (2) step();
        check("nw32_busy_cnt", 32'(busy_cnt), 32'd0);
        check("nw32_pulse_cnt", 32'(wr32_cnt), 32'd0);
        check("nw32_data", bus.wr32_data, 32'd0);
        check("nw32_err", 32'(short_cnt + range_cnt), 32'd0);
`endif

        // Reset during QUAL8 at count 2, strobe still high at release.
        clr_mon();
        bus.addr_in = 8'h03; bus.data_in = 8'h99; bus.sw_in = 1'b1;
        step();
        step();
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("mid_rst_no_pulse", 32'(wr_cnt + short_cnt + range_cnt), 32'd0);
        rst_n = 1'b1;
        clr_mon();
        step();
        check("mid_requal_busy", 32'(bus.busy), 32'd1);
        bus.rd_addr = 8'h0A; bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        check("mid_rd_cleared_vld", 32'(bus.rd_valid), 32'd1);
        check("mid_rd_cleared", 32'(bus.rd_data), 32'd0);
        repeat (5) step();
        check("mid_requal_wr_cnt", 32'(wr_cnt), 32'd1);
        check("mid_requal_latency", 32'(wr_at), 32'd4);
        check("mid_requal_err", 32'(short_cnt + range_cnt), 32'd0);
        bus.sw_in = 1'b0;
        repeat (3) step();
        rd_check("mid_rd_new", 8'h03, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmd_receiver.md
CMD_RECEIVER -- requirements
Module: cmd_receiver

Interface
REQ-001 SHALL have parameter NREG, default 16, number of 8-bit registers (addresses 0..NREG-1, NREG<=256).
REQ-002 SHALL have parameter QUAL, default 4, consecutive high samples of a strobe that qualify a write (1..255).
REQ-003 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have addr_in  input  8  command address; data_in  input  8  command byte; sw_in  input  1  stretched 8-bit write strobe.
REQ-006 SHALL have data32_in  input  32  command word; sw32_in  input  1  stretched 32-bit write strobe.
REQ-007 SHALL have rd_addr  input  8  readback address; rd_req  input  1  one-cycle readback request.
REQ-008 SHALL have wr_pulse  output  1  one-cycle commit strobe; wr_addr  output  8; wr_data  output  8  committed address/byte.
REQ-009 SHALL have wr32_pulse  output  1; wr32_data  output  32  committed word.
REQ-010 SHALL have rd_data  output  8; rd_valid  output  1  readback result/strobe.
REQ-011 SHALL have err_short  output  1; err_range  output  1  one-cycle error pulses; busy  output  1  FSM not IDLE.

Function
REQ-012 SHALL register sw_in/sw32_in each cycle (sw_q, sw32_q); rising edge = input high AND registered copy low.
REQ-013 SHALL implement FSM states IDLE, QUAL8, QUAL32, COMMIT8, COMMIT32, HOLD; encoding safe, illegal states return to IDLE.
REQ-014 IDLE: sw_in rising -> QUAL8, count=1; else sw32_in rising -> QUAL32, count=1; both rising same cycle -> QUAL8 (8-bit priority).
REQ-015 QUALx: strobe high -> count+1; when count reaches QUAL, capture addr_in/data_in (or data32_in) that same cycle and go COMMITx; with QUAL=1 capture occurs on the edge cycle.
REQ-016 QUALx: strobe low before count==QUAL -> err_short one cycle, no write, -> IDLE.
REQ-017 COMMIT8 (one cycle): addr<NREG -> reg[addr]<=data, wr_pulse=1, wr_addr/wr_data updated; addr>=NREG -> no write, err_range=1, wr_addr/wr_data unchanged; -> HOLD.
REQ-018 COMMIT32 (one cycle): wr32_data<=captured word, wr32_pulse=1; -> HOLD.
REQ-019 HOLD: remain until sw_in AND sw32_in both low, then -> IDLE; no new command accepted in HOLD; a strobe held indefinitely yields exactly one commit.
REQ-020 Latency: first high sample at edge t -> wr_pulse/wr32_pulse high during cycle t+QUAL.
REQ-021 Readback: rd_req at edge t -> rd_valid=1 and rd_data=reg[rd_addr] during cycle t+1; rd_addr>=NREG returns 0x00; rd_req and COMMIT8 to the same address at edge t return the pre-write value.
REQ-022 Readback SHALL operate in every FSM state and never stall.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 reset low at a clock edge SHALL force IDLE, count=0, all registers 0x00, sw_q=sw32_q=0, every output 0, overriding any in-progress QUAL/COMMIT/HOLD (no commit, no error pulse).
REQ-025 After reset release with strobe already high, sw_q=0 SHALL cause a rising edge on the first post-reset cycle.

Configuration
REQ-026 Macro CMD_RECEIVER_DATA32_EN: defined -> 32-bit path (QUAL32, COMMIT32, wr32_pulse, wr32_data) present per REQ-014..020.
REQ-027 Without CMD_RECEIVER_DATA32_EN: sw32_in and data32_in ignored, QUAL32/COMMIT32 absent, wr32_pulse and wr32_data tied 0, HOLD waits on sw_in only.

Verification
REQ-028 addr_in=0x03, data_in=0xA5, sw_in high 20 cycles, QUAL=4 -> one wr_pulse 4 cycles after first high sample, wr_addr=0x03, wr_data=0xA5; rd_addr=0x03 read -> rd_data=0xA5 next cycle.
REQ-029 sw_in high 2 cycles, QUAL=4 -> err_short one pulse, no wr_pulse, register unchanged (0x00).
REQ-030 addr_in=0x20, NREG=16, sw_in high 20 cycles -> err_range one pulse, no wr_pulse; rd_addr=0x20 -> rd_data=0x00.
REQ-031 sw_in and sw32_in rise same cycle, data32_in=0xDEADBEEF, macro defined -> only wr_pulse; sw32_in ignored until both low; later sw32_in alone -> wr32_pulse, wr32_data=0xDEADBEEF.
REQ-032 reset low during QUAL8 at count 2 -> no commit, busy=0, all registers 0x00; strobe still high at release -> new qualification from count 1.
REQ-033 macro undefined, sw32_in high 20 cycles -> busy stays 0, wr32_pulse=0, wr32_data=0.
